// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: PC sequencing, stall hold, redirect with one-cycle bubble,
// and a saturating count of instructions accepted downstream.
module pc_fetch_unit #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h00000000,
  parameter int          IMEM_AW   = 6,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [ADDR_W-1:0]  PC,
  output logic [ADDR_W-1:0]  PC_new,
  output logic [31:0]        inst_code,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic               inst_valid,
  output logic               misalign_err,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [ADDR_W-1:0] RESET_PC = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              fvalid_q, fvalid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mis_q, mis_d;

  // While stalled the ROM re-reads the issued fetch so inst_code stays put.
  assign imem_addr    = (stall && !redirect_valid) ? fpc_q[IMEM_AW+1:2] : pc_q[IMEM_AW+1:2];
  assign PC           = pc_q;
  assign PC_new       = pc_q + STEP;
  assign inst_code    = imem_rdata;
  assign inst_pc      = fpc_q;
  assign inst_valid   = fvalid_q;
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;

  always_comb begin
    pc_d     = pc_q;
    fpc_d    = fpc_q;
    fvalid_d = fvalid_q;
    cnt_d    = cnt_q;
    mis_d    = 1'b0;
    if (redirect_valid) begin
      // Squash whatever is in flight; the target word is read next cycle.
      pc_d     = {redirect_target[ADDR_W-1:2], 2'b00};
      fvalid_d = 1'b0;
      mis_d    = |redirect_target[1:0];
    end else if (!stall) begin
      fpc_d    = pc_q;
      fvalid_d = 1'b1;
      pc_d     = pc_q + STEP;
      if (fvalid_q && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      fpc_q    <= RESET_PC;
      fvalid_q <= 1'b0;
      cnt_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      fpc_q    <= fpc_d;
      fvalid_q <= fvalid_d;
      cnt_q    <= cnt_d;
      mis_q    <= mis_d;
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC / target width.
REQ-002 SHALL have parameter RESET_VEC, default 32'h00000000: first fetch address, truncated to ADDR_W.
REQ-003 SHALL have parameter IMEM_AW, default 6: instruction-memory word-index width.
REQ-004 SHALL have parameter CNT_W, default 16: delivered-instruction counter width.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port stall  input  1: downstream cannot accept the current instruction.
REQ-008 SHALL have port redirect_valid  input  1: branch/jump taken this cycle.
REQ-009 SHALL have port redirect_target  input  ADDR_W: new fetch address.
REQ-010 SHALL have port imem_addr  output  IMEM_AW: word index to synchronous ROM (1-cycle read latency).
REQ-011 SHALL have port imem_rdata  input  32: ROM read data.
REQ-012 SHALL have port PC  output  ADDR_W: address of the fetch being issued.
REQ-013 SHALL have port PC_new  output  ADDR_W: PC+4, modulo 2^ADDR_W.
REQ-014 SHALL have port inst_code  output  32: current instruction, equal to imem_rdata.
REQ-015 SHALL have port inst_pc  output  ADDR_W: address of inst_code.
REQ-016 SHALL have port inst_valid  output  1: inst_code/inst_pc are meaningful.
REQ-017 SHALL have port misalign_err  output  1: one-cycle pulse for a redirect target with [1:0]!=0.
REQ-018 SHALL have port fetch_count  output  CNT_W: number of accepted instructions.

Function
REQ-019 SHALL hold internal state: PC register, issued-fetch register f_pc, issued flag f_valid, fetch_count, misalign_err register.
REQ-020 SHALL drive imem_addr = PC[IMEM_AW+1:2], except f_pc[IMEM_AW+1:2] when stall=1 and redirect_valid=0.
REQ-021 SHALL drive inst_valid = f_valid, inst_pc = f_pc, inst_code = imem_rdata (combinational).
REQ-022 Advance (stall=0, redirect_valid=0): f_pc<=PC, f_valid<=1, PC<=PC+4; one instruction per cycle, first instruction valid 1 cycle after reset release.
REQ-023 Stall (stall=1, redirect_valid=0): PC, f_pc, f_valid, fetch_count hold; the ROM re-reads f_pc so inst_code stays stable across the stall.
REQ-024 Redirect (redirect_valid=1, stall ignored): PC<={redirect_target[ADDR_W-1:2],2'b00}, f_valid<=0; exactly one bubble cycle (inst_valid=0), then target instruction valid.
REQ-025 The in-flight instruction at a redirect SHALL be squashed; never delivered.
REQ-026 misalign_err SHALL be 1 in the cycle after a redirect whose target[1:0]!=0, otherwise 0.
REQ-027 fetch_count SHALL increment when inst_valid=1 and stall=0 and redirect_valid=0; SHALL saturate at all-ones.
REQ-028 PC SHALL wrap to 0 after 2^ADDR_W-4; imem_addr wraps naturally at the ROM depth.
REQ-029 Back-to-back redirects SHALL each take effect; only the last target is fetched, inst_valid stays 0 until one cycle after the last.

Reset
REQ-030 reset=0 SHALL immediately (no clock) force PC=RESET_VEC, f_pc=RESET_VEC, f_valid=0, misalign_err=0, fetch_count=0; so inst_valid=0, PC_new=RESET_VEC+4.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; first edge after release behaves per REQ-022.

Verification
REQ-032 Boot: release reset, stall=0 -> PC 0,4,8,... per cycle; inst_valid=1 from cycle 1 with inst_pc=0, inst_code=ROM[0]; fetch_count=3 after 3 valid cycles.
REQ-033 Stall: stall=1 for 3 cycles while inst_pc=8 -> inst_pc=8, inst_code=ROM[2], PC=12, fetch_count unchanged; after release inst_pc=12 next cycle.
REQ-034 Redirect: redirect_target=0x40 while inst_pc=4 -> next cycle inst_valid=0, PC=0x40; following cycle inst_pc=0x40, inst_code=ROM[16]; instruction at 8 never valid.
REQ-035 Misaligned: redirect_target=0x22 -> misalign_err=1 for exactly one cycle, then inst_pc=0x20.
REQ-036 Redirect during stall, then async reset mid-run: redirect wins over stall; reset=0 between edges -> inst_valid=0, PC=RESET_VEC before the next edge.
REQ-037 Saturation/wrap: CNT_W=2 -> fetch_count stops at 3; ADDR_W=8, PC=0xFC -> next PC=0x00.
